// File: rtl/param_register_file_pkg.sv
// Shared definitions for the parametrised register file: clear-sequencer state
// encoding and default geometry.
package param_register_file_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 2;

endpackage

// File: rtl/param_register_file_clear_seq.sv
// Clear sequencer: walks an index over every register file entry, one per
// cycle, then pulses done for one cycle.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | normal operation, waiting for ClearReq
//   ST_CLEAR | zeroing entry clear_idx this cycle, writes discarded
//   ST_DONE  | last entry zeroed, ClearDone high, writes accepted
module regfile_clear_seq
    import param_register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  ClearReq,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_idx,
    output logic                  write_ok,
    output logic                  ClearBusy,
    output logic                  ClearDone
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    clr_state_e            state, state_next;
    logic [ADDR_WIDTH-1:0] counter;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && ClearReq)
                counter <= '0;
            else if (state == ST_CLEAR && counter != LAST_IDX)
                counter <= counter + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ClearReq) state_next = ST_CLEAR;
            ST_CLEAR: if (counter == LAST_IDX) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        clear_we  = (state == ST_CLEAR);
        clear_idx = counter;
        ClearBusy = (state == ST_CLEAR);
        ClearDone = (state == ST_DONE);
        write_ok  = (state != ST_CLEAR);
    end

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: two combinational read ports, one clocked write
// port, optional hardwired-zero R0 and a hardware clear sequencer.
// Build option: define REGFILE_BYPASS_EN to forward accepted write data to reads.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] RS,
    input  logic [ADDR_WIDTH-1:0] RT,
    input  logic [ADDR_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  ClearReq,
    output logic [DATA_WIDTH-1:0] ReadRS,
    output logic [DATA_WIDTH-1:0] ReadRT,
    output logic                  ClearBusy,
    output logic                  ClearDone,
    output logic                  WriteDrop
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_idx;
    logic                  write_ok;
    logic                  wr_acc;

    regfile_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .ClearReq  (ClearReq),
        .clear_we  (clear_we),
        .clear_idx (clear_idx),
        .write_ok  (write_ok),
        .ClearBusy (ClearBusy),
        .ClearDone (ClearDone)
    );

    assign wr_acc    = RegWrite && write_ok && !(ZERO_REG != 0 && RD == '0);
    assign WriteDrop = RegWrite && ClearBusy;

    // Clear has priority; the sequencer blocks ordinary writes while active anyway.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (clear_we) begin
            regs[clear_idx] <= '0;
        end else if (wr_acc) begin
            regs[RD] <= WriteData;
        end
    end

    always_comb begin
        ReadRS = (ZERO_REG != 0 && RS == '0) ? '0 : regs[RS];
        ReadRT = (ZERO_REG != 0 && RT == '0) ? '0 : regs[RT];
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && RS == RD) ReadRS = WriteData;
        if (wr_acc && RT == RD) ReadRT = WriteData;
`endif
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench for param_register_file: default geometry with
// and without hardwired R0, plus a 32x8 instance for mid-clear reset.
module tb_param_register_file;

    logic        Clock = 1'b0;
    logic        rst_n;
    logic [1:0]  rs, rt, rd;
    logic [15:0] wdata;
    logic        regwrite, clearreq;
    logic [15:0] a_rs, a_rt, b_rs, b_rt;
    logic        a_busy, a_done, a_drop, b_busy, b_done, b_drop;

    logic        rst_w_n;
    logic [2:0]  rs_w, rt_w, rd_w;
    logic [31:0] wdata_w;
    logic        regwrite_w, clearreq_w;
    logic [31:0] c_rs, c_rt;
    logic        c_busy, c_done, c_drop;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 Clock = ~Clock;

    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .ZERO_REG(1)) u_dut_a (
        .Clock(Clock), .Reset_n(rst_n), .RS(rs), .RT(rt), .RD(rd), .WriteData(wdata),
        .RegWrite(regwrite), .ClearReq(clearreq), .ReadRS(a_rs), .ReadRT(a_rt),
        .ClearBusy(a_busy), .ClearDone(a_done), .WriteDrop(a_drop));

    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .ZERO_REG(0)) u_dut_b (
        .Clock(Clock), .Reset_n(rst_n), .RS(rs), .RT(rt), .RD(rd), .WriteData(wdata),
        .RegWrite(regwrite), .ClearReq(clearreq), .ReadRS(b_rs), .ReadRT(b_rt),
        .ClearBusy(b_busy), .ClearDone(b_done), .WriteDrop(b_drop));

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG(0)) u_dut_c (
        .Clock(Clock), .Reset_n(rst_w_n), .RS(rs_w), .RT(rt_w), .RD(rd_w), .WriteData(wdata_w),
        .RegWrite(regwrite_w), .ClearReq(clearreq_w), .ReadRS(c_rs), .ReadRT(c_rt),
        .ClearBusy(c_busy), .ClearDone(c_done), .WriteDrop(c_drop));

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_w_n = 1'b0;
        rs = '0; rt = '0; rd = '0; wdata = '0; regwrite = 1'b0; clearreq = 1'b0;
        rs_w = '0; rt_w = '0; rd_w = '0; wdata_w = '0; regwrite_w = 1'b0; clearreq_w = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            rs = 2'(i); rt = 2'(3 - i);
            #1;
            cmp_cnt++;
            if (a_rs !== 16'h0 || a_rt !== 16'h0 || b_rs !== 16'h0 || b_rt !== 16'h0) begin
                err_cnt++;
                $display("FAIL reset_read idx %0d: got %h %h %h %h, want 0000", i, a_rs, a_rt, b_rs, b_rt);
            end
        end
        cmp_cnt++;
        if ({a_busy, a_done, b_busy, b_done} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b, want 0000", {a_busy, a_done, b_busy, b_done});
        end
        rst_n = 1'b1; rst_w_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        rd = 2'd2; wdata = 16'hABCD; regwrite = 1'b1; rs = 2'd2; rt = 2'd3;
        step();
        regwrite = 1'b0;
        #1;
        cmp_cnt++;
        if (a_rs !== 16'hABCD || b_rs !== 16'hABCD) begin
            err_cnt++;
            $display("FAIL write_r2: got %h/%h, want abcd", a_rs, b_rs);
        end
        cmp_cnt++;
        if (a_rt !== 16'h0) begin
            err_cnt++;
            $display("FAIL write_r3_untouched: got %h, want 0000", a_rt);
        end
    endtask

    task automatic test_zero_reg();
        rd = 2'd0; wdata = 16'h1234; regwrite = 1'b1;
        step();
        regwrite = 1'b0; rs = 2'd0; rt = 2'd0;
        #1;
        cmp_cnt++;
        if (a_rs !== 16'h0 || a_rt !== 16'h0) begin
            err_cnt++;
            $display("FAIL zero_reg_on: got %h/%h, want 0000", a_rs, a_rt);
        end
        cmp_cnt++;
        if (b_rs !== 16'h1234) begin
            err_cnt++;
            $display("FAIL zero_reg_off: got %h, want 1234", b_rs);
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        int done_at;
        for (int i = 1; i < 4; i++) begin
            rd = 2'(i); wdata = 16'(i * 16'h1111); regwrite = 1'b1;
            step();
        end
        regwrite = 1'b0;
        clearreq = 1'b1;
        step();
        clearreq = 1'b0;
        rs = 2'd0; rt = 2'd2;
        #1;
        busy_cnt = 0; done_at = -1;
        for (int k = 0; k < 10; k++) begin
            if (a_busy) busy_cnt++;
            if (k == 0) begin
                cmp_cnt++;
                if (b_rs !== 16'h1234 || b_rt !== 16'h2222) begin
                    err_cnt++;
                    $display("FAIL clear_k0_reads: got %h/%h, want 1234/2222", b_rs, b_rt);
                end
            end
            if (k == 1) begin
                cmp_cnt++;
                if (b_rs !== 16'h0 || b_rt !== 16'h2222) begin
                    err_cnt++;
                    $display("FAIL clear_k1_reads: got %h/%h, want 0000/2222", b_rs, b_rt);
                end
            end
            if (a_done) begin
                done_at = k;
                break;
            end
            step();
        end
        cmp_cnt++;
        if (busy_cnt != 4 || done_at != 4) begin
            err_cnt++;
            $display("FAIL clear_timing: busy %0d done_at %0d, want 4 4", busy_cnt, done_at);
        end
        step();
        cmp_cnt++;
        if ({a_busy, a_done} !== 2'b00) begin
            err_cnt++;
            $display("FAIL clear_idle_flags: got %b, want 00", {a_busy, a_done});
        end
        for (int i = 0; i < 4; i++) begin
            rs = 2'(i); rt = 2'(i);
            #1;
            cmp_cnt++;
            if (a_rs !== 16'h0 || b_rs !== 16'h0 || b_rt !== 16'h0) begin
                err_cnt++;
                $display("FAIL clear_all_zero idx %0d: got %h %h %h, want 0000", i, a_rs, b_rs, b_rt);
            end
        end
    endtask

    task automatic test_drop_in_clear();
        bit seen_done;
        clearreq = 1'b1;
        step();
        clearreq = 1'b0;
        rd = 2'd3; wdata = 16'hBEEF; regwrite = 1'b1;
        #1;
        cmp_cnt++;
        if (a_drop !== 1'b1) begin
            err_cnt++;
            $display("FAIL drop_in_clear: got %b, want 1", a_drop);
        end
        step();
        regwrite = 1'b0;
        #1;
        cmp_cnt++;
        if (a_drop !== 1'b0) begin
            err_cnt++;
            $display("FAIL drop_deassert: got %b, want 0", a_drop);
        end
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (a_done) begin
                seen_done = 1'b1;
                break;
            end
            step();
        end
        cmp_cnt++;
        if (!seen_done) begin
            err_cnt++;
            $display("FAIL drop_wait_done: got timeout, want ClearDone");
        end
        rs = 2'd3;
        #1;
        cmp_cnt++;
        if (a_rs !== 16'h0) begin
            err_cnt++;
            $display("FAIL dropped_write_r3: got %h, want 0000", a_rs);
        end
        rd = 2'd3; wdata = 16'hBEEF; regwrite = 1'b1; clearreq = 1'b1;
        #1;
        cmp_cnt++;
        if (a_drop !== 1'b0) begin
            err_cnt++;
            $display("FAIL drop_in_done: got %b, want 0", a_drop);
        end
        step();
        regwrite = 1'b0; clearreq = 1'b0;
        #1;
        cmp_cnt++;
        if (a_rs !== 16'hBEEF) begin
            err_cnt++;
            $display("FAIL write_in_done: got %h, want beef", a_rs);
        end
        cmp_cnt++;
        if (a_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL clearreq_in_done_ignored: busy %b, want 0", a_busy);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 16'h00FF;
`else
        exp_same = 16'h0000;
`endif
        rs = 2'd1; rt = 2'd1; rd = 2'd1; wdata = 16'h00FF; regwrite = 1'b1;
        #1;
        cmp_cnt++;
        if (a_rs !== exp_same || a_rt !== exp_same) begin
            err_cnt++;
            $display("FAIL bypass_same_cycle: got %h/%h, want %h", a_rs, a_rt, exp_same);
        end
        step();
        regwrite = 1'b0;
        #1;
        cmp_cnt++;
        if (a_rs !== 16'h00FF || a_rt !== 16'h00FF) begin
            err_cnt++;
            $display("FAIL bypass_after_edge: got %h/%h, want 00ff", a_rs, a_rt);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit done_seen;
        for (int i = 0; i < 8; i++) begin
            rd_w = 3'(i); wdata_w = 32'h1000_0000 + 32'(i); regwrite_w = 1'b1;
            step();
        end
        regwrite_w = 1'b0;
        rs_w = 3'd5;
        clearreq_w = 1'b1;
        step();
        clearreq_w = 1'b0;
        step();
        cmp_cnt++;
        if (c_busy !== 1'b1 || c_rs !== 32'h1000_0005) begin
            err_cnt++;
            $display("FAIL wide_clear2_state: busy %b r5 %h, want 1 10000005", c_busy, c_rs);
        end
        rst_w_n = 1'b0;
        #1;
        cmp_cnt++;
        if ({c_busy, c_done} !== 2'b00) begin
            err_cnt++;
            $display("FAIL wide_async_flags: got %b, want 00", {c_busy, c_done});
        end
        for (int i = 0; i < 8; i++) begin
            rs_w = 3'(i); rt_w = 3'(7 - i);
            #1;
            cmp_cnt++;
            if (c_rs !== 32'h0 || c_rt !== 32'h0) begin
                err_cnt++;
                $display("FAIL wide_reset_zero idx %0d: got %h/%h, want 00000000", i, c_rs, c_rt);
            end
        end
        step();
        rst_w_n = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (c_done || c_busy) done_seen = 1'b1;
            step();
        end
        cmp_cnt++;
        if (done_seen) begin
            err_cnt++;
            $display("FAIL wide_no_done_after_abort: got activity, want none");
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_zero_reg();
        test_clear();
        test_drop_in_clear();
        test_bypass();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
